serial_parallel: RTL and testbench

Serial-to-parallel receiver; the receive end of the `parallel_serial` link. Samples one serial bit per `clk_32f` cycle, MSB first, and finds the byte boundary by hunting for the comma character 0xBC. It declares lock after a run of aligned commas, then delivers each non-comma byte as 8-bit parallel data with a valid flag.

---
 rtl/serial_parallel_pkg.sv | 14 +
 rtl/serial_parallel_if.sv | 24 ++
 rtl/serial_parallel_comma_align_fsm.sv | 71 +++++++
 rtl/serial_parallel.sv | 68 ++++++
 tb/tb_serial_parallel.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_parallel_pkg.sv
// Shared constants and state encoding for the serial_parallel receiver.
// Build option: SERIAL_PARALLEL_COMMA_PASS_EN (see serial_parallel.sv).
package serial_parallel_pkg;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StAlign  = 2'd1,
        StActive = 2'd2
    } state_e;

    localparam logic [7:0]  DefaultComma     = 8'hBC;
    localparam int unsigned DefaultLockCount = 4;

endpackage

// File: rtl/serial_parallel_if.sv
// Serial input and parallel output bundle of the serial_parallel receiver.
// Build option: SERIAL_PARALLEL_COMMA_PASS_EN changes only the receiver, not this bundle.
interface serial_parallel_if;

    logic       Data_in;
    logic [7:0] Data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output Data_in,
        input  Data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  Data_in,
        output Data_out,
        output valid_out,
        output active
    );

endinterface

// File: rtl/serial_parallel_comma_align_fsm.sv
// Comma hunt and lock FSM: owns state, bit counter and aligned-comma counter.
// Build option: SERIAL_PARALLEL_COMMA_PASS_EN has no effect here.
module serial_parallel_comma_align_fsm
    import serial_parallel_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = DefaultLockCount
) (
    input  logic clk_32f,
    input  logic reset,
    input  logic is_comma,
    output logic boundary,
    output logic active
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= StSearch;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        boundary  = (state_q != StSearch) && (bit_cnt_q == 3'd7);
        active    = (state_q == StActive);

        unique case (state_q)
            StSearch: begin
                // Restart the counter so the next boundary lands 8 bits after this comma.
                bit_cnt_d = 3'd0;
                if (is_comma) begin
                    bc_cnt_d = 4'd1;
                    state_d  = (LockCnt == 4'd1) ? StActive : StAlign;
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if (bc_cnt_q + 4'd1 == LockCnt) begin
                            state_d = StActive;
                        end
                    end else begin
                        bc_cnt_d = 4'd0;
                        state_d  = StSearch;
                    end
                end
            end
            StActive: begin
                state_d = StActive;
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

endmodule

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver: comma-aligned byte recovery, MSB first.
// Build option: define SERIAL_PARALLEL_COMMA_PASS_EN to deliver commas as valid bytes in ACTIVE.
module serial_parallel
    import serial_parallel_pkg::*;
#(
    parameter logic [7:0]  COMMA      = DefaultComma,
    parameter int unsigned LOCK_COUNT = DefaultLockCount
) (
    input logic               clk_32f,
    input logic               reset,
    serial_parallel_if.slave  bus
);

    logic [7:0] sr_q, sr_next;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       is_comma;
    logic       boundary;
    logic       active;

    assign sr_next  = {sr_q[6:0], bus.Data_in};
    assign is_comma = (sr_next == COMMA);

    serial_parallel_comma_align_fsm #(
        .LOCK_COUNT (LOCK_COUNT)
    ) u_fsm (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .is_comma (is_comma),
        .boundary (boundary),
        .active   (active)
    );

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (active && boundary) begin
            if (!is_comma) begin
                data_d  = sr_next;
                valid_d = 1'b1;
            end else begin
`ifdef SERIAL_PARALLEL_COMMA_PASS_EN
                data_d  = COMMA;
                valid_d = 1'b1;
`else
                valid_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_next;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active;

endmodule

// File: tb/tb_serial_parallel.sv
// Self-checking bench for serial_parallel: directed link scenarios plus random byte streams,
// every bit compared against a bit-position-based reference model.
module tb_serial_parallel;

    localparam logic [7:0]  COMMA = 8'hBC;
    localparam int unsigned LOCK  = 4;

    logic clk;
    logic reset;

    serial_parallel_if bus ();

    serial_parallel #(
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk_32f (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 hunting, 1 counting commas, 2 locked.
    int         m_win;
    int         m_mode;
    int         m_cnt;
    int         m_pos;
    int         m_anchor;
    logic [7:0] m_dout;
    logic       m_vld;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win    = 0;
        m_mode   = 0;
        m_cnt    = 0;
        m_pos    = 0;
        m_anchor = 0;
        m_dout   = 8'h00;
        m_vld    = 1'b0;
    endtask

    task automatic model_step(input logic b);
        bit on_byte;
        m_pos++;
        m_win   = ((m_win << 1) | int'(b)) & 255;
        on_byte = ((m_pos - m_anchor) % 8) == 0;
        if (m_mode == 0) begin
            if (m_win == int'(COMMA)) begin
                m_anchor = m_pos;
                m_cnt    = 1;
                m_mode   = (LOCK == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (on_byte) begin
                if (m_win == int'(COMMA)) begin
                    m_cnt++;
                    if (m_cnt == int'(LOCK)) m_mode = 2;
                end else begin
                    m_cnt  = 0;
                    m_mode = 0;
                end
            end
        end else if (on_byte) begin
            if (m_win != int'(COMMA)) begin
                m_dout = 8'(m_win);
                m_vld  = 1'b1;
            end else begin
`ifdef SERIAL_PARALLEL_COMMA_PASS_EN
                m_dout = COMMA;
                m_vld  = 1'b1;
`else
                m_vld  = 1'b0;
`endif
            end
        end
    endtask

    task automatic check_model();
        check_eq("data_out", 32'(bus.Data_out), 32'(m_dout));
        check_eq("valid_out", 32'(bus.valid_out), 32'(m_vld));
        check_eq("active", 32'(bus.active), 32'(m_mode == 2));
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_data"}, 32'(bus.Data_out), 32'h00);
        check_eq({tag, "_valid"}, 32'(bus.valid_out), 32'h0);
        check_eq({tag, "_active"}, 32'(bus.active), 32'h0);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.Data_in = b;
        @(posedge clk);
        #1;
        model_step(b);
        check_model();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Reset asserted on the falling edge so the clear is seen before any rising edge.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset       = 1'b0;
        bus.Data_in = 1'($urandom);
        #1;
        check_cleared("async_rst");
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.Data_in = 1'($urandom);
            @(posedge clk);
            #1;
            check_cleared("in_rst");
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        bus.Data_in = 1'b0;
        model_reset();

        // Lock then two data bytes.
        do_reset(2);
        repeat (3) send_byte(COMMA);
        check_eq("lock_a_pre", 32'(bus.active), 32'h0);
        send_byte(COMMA);
        check_eq("lock_a", 32'(bus.active), 32'h1);
        send_byte(8'h55);
        check_eq("data_55", 32'(bus.Data_out), 32'h55);
        check_eq("valid_55", 32'(bus.valid_out), 32'h1);
        send_byte(8'hA3);
        check_eq("data_a3", 32'(bus.Data_out), 32'hA3);

        // Comma run broken by a data byte before lock.
        do_reset(1);
        repeat (3) send_byte(COMMA);
        send_byte(8'h00);
        check_eq("lock_fail", 32'(bus.active), 32'h0);
        repeat (4) send_byte(COMMA);
        check_eq("relock_b", 32'(bus.active), 32'h1);
        send_byte(8'h0F);
        check_eq("data_0f", 32'(bus.Data_out), 32'h0F);

        // Misaligned start.
        do_reset(1);
        repeat (3) send_bit(1'b1);
        repeat (5) send_byte(COMMA);
        send_byte(8'h3C);
        check_eq("data_3c", 32'(bus.Data_out), 32'h3C);
        check_eq("valid_3c", 32'(bus.valid_out), 32'h1);

        // Idle comma while locked.
        do_reset(1);
        repeat (4) send_byte(COMMA);
        send_byte(8'h12);
        check_eq("idle_d0", 32'(bus.Data_out), 32'h12);
        check_eq("idle_v0", 32'(bus.valid_out), 32'h1);
        send_byte(COMMA);
`ifdef SERIAL_PARALLEL_COMMA_PASS_EN
        check_eq("idle_d1", 32'(bus.Data_out), 32'hBC);
        check_eq("idle_v1", 32'(bus.valid_out), 32'h1);
`else
        check_eq("idle_d1", 32'(bus.Data_out), 32'h12);
        check_eq("idle_v1", 32'(bus.valid_out), 32'h0);
`endif
        send_byte(8'h34);
        check_eq("idle_d2", 32'(bus.Data_out), 32'h34);
        check_eq("idle_v2", 32'(bus.valid_out), 32'h1);

        // Reset pulse in the middle of a data byte while locked.
        do_reset(1);
        repeat (4) send_byte(COMMA);
        send_byte(8'h77);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h5A >> i));
        do_reset(1);
        for (int i = 3; i >= 0; i--) send_bit(1'(8'h5A >> i));
        repeat (3) send_byte(COMMA);
        check_eq("relock_e_pre", 32'(bus.active), 32'h0);
        send_byte(COMMA);
        check_eq("relock_e", 32'(bus.active), 32'h1);

        // Random streams: random bit prefix, then a comma/data mix.
        for (int run = 0; run < 4; run++) begin
            do_reset(1);
            repeat ($urandom_range(0, 7)) send_bit(1'($urandom));
            for (int k = 0; k < 120; k++) begin
                if (($urandom % 2) == 0 || k < 6) send_byte(COMMA);
                else send_byte(8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
